// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - round-robin scheduler sharing one fsm_counter between NREQ requesters
module counter_sched #(
  parameter int NREQ = 2,
  parameter int CW   = 3,
  parameter int TMO  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   len,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [CW-1:0]        result,
  output logic                 busy,
  output logic                 cnt_start,
  output logic                 cnt_stop,
  input  logic [CW-1:0]        cnt_value
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int RW = (TMO > 1) ? $clog2(TMO) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]      state;
  logic [GW-1:0]   g;
  logic [GW-1:0]   ptr;
  logic [CW-1:0]   tgt;
  logic [RW-1:0]   rc;
  logic            err_r;
  logic [NREQ-1:0] g_oh;

  logic [GW-1:0]   pick;
  logic [GW-1:0]   hi;
  logic [GW-1:0]   lo;
  logic            hi_any;
  logic [CW-1:0]   len_pick;

  // Descending scan leaves the lowest set index overall (lo) and the lowest at/after ptr (hi).
  always_comb begin
    hi     = '0;
    lo     = '0;
    hi_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo = GW'(i);
        if (i >= int'(ptr)) begin
          hi     = GW'(i);
          hi_any = 1'b1;
        end
      end
    end
    pick = hi_any ? hi : lo;
  end

  always_comb begin
    len_pick = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == GW'(i)) len_pick = len[i*CW +: CW];
    end
  end

  assign g_oh      = {{(NREQ-1){1'b0}}, 1'b1} << g;
  assign busy      = (state != IDLE);
  assign gnt       = busy ? g_oh : '0;
  assign done      = (state == DONE) ? g_oh : '0;
  assign err       = (state == DONE) & err_r;
  assign cnt_start = (state == START);
  assign cnt_stop  = (state == STOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      g      <= '0;
      ptr    <= '0;
      tgt    <= '0;
      rc     <= '0;
      result <= '0;
      err_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            g     <= pick;
            tgt   <= len_pick;
            rc    <= '0;
            state <= START;
          end
        end
        START: state <= RUN;
        RUN: begin
          rc <= rc + 1'b1;
          // Match beats abort beats timeout when several hold in the same cycle.
          if (cnt_value == tgt) begin
            result <= cnt_value;
            err_r  <= 1'b0;
            state  <= STOP;
          end else if (!(|(req & g_oh))) begin
            result <= cnt_value;
            err_r  <= 1'b1;
            state  <= STOP;
          end else if (rc == RW'(TMO - 1)) begin
            result <= cnt_value;
            err_r  <= 1'b1;
            state  <= STOP;
          end
        end
        STOP: state <= DONE;
        DONE: begin
          ptr   <= (g == GW'(NREQ - 1)) ? '0 : g + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
